// File: rtl/modbus_rx_framer.sv
// Modbus RTU receive framer: t1.5/t3.5 silence delimiting, frame buffer, CRC/length/address check.
// Optional `MODBUS_RX_BROADCAST_EN accepts address 0x00 in addition to dev_addr.
module modbus_rx_framer #(
  parameter int unsigned T15_CYCLES = 85938,
  parameter int unsigned T35_CYCLES = 200521,
  parameter int unsigned MAX_LEN    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic [7:0]  dev_addr,
  output logic        crc_en,
  output logic        crc_clr,
  output logic [7:0]  crc_data,
  input  logic [15:0] crc_in,
  output logic        busy,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [8:0]  frame_len,
  input  logic [7:0]  buf_rd_addr,
  output logic [7:0]  buf_rd_data
);

  localparam int unsigned SilW  = $clog2(T35_CYCLES + 1);
  localparam int unsigned AddrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [SilW-1:0] T15    = SilW'(T15_CYCLES);
  localparam logic [SilW-1:0] T35    = SilW'(T35_CYCLES);
  localparam logic [8:0]      MaxLen = 9'(MAX_LEN);

  localparam logic [1:0] ErrCrc   = 2'd0;
  localparam logic [1:0] ErrShort = 2'd1;
  localparam logic [1:0] ErrOvf   = 2'd2;
  localparam logic [1:0] ErrGap   = 2'd3;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRecv,
    StGap,
    StCheck
  } state_e;

  state_e state_q, state_d;

  logic [SilW-1:0] sil_q, sil_d;
  logic [8:0]      cnt_q, cnt_d;
  logic            gap_q, gap_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      first_q, first_d;
  logic            init_q;

  logic            crc_en_q, crc_en_d;
  logic            crc_clr_q, crc_clr_d;
  logic [7:0]      crc_data_q, crc_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [8:0]      frame_len_q, frame_len_d;
  logic [7:0]      rd_data_q;

  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [AddrW-1:0] rd_idx;
  logic             rd_in_range;
  logic             addr_ok;
  logic             bcast_ok;

  logic [7:0] frame_mem [MAX_LEN];

`ifdef MODBUS_RX_BROADCAST_EN
  assign bcast_ok = (first_q == 8'h00);
`else
  assign bcast_ok = 1'b0;
`endif

  assign addr_ok = (first_q == dev_addr) || bcast_ok;

  // Silence counter: any UART event restarts it; it parks at t3.5.
  always_comb begin
    if (rx_valid || rx_err) begin
      sil_d = '0;
    end else if (sil_q == T35) begin
      sil_d = sil_q;
    end else begin
      sil_d = sil_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    ovf_d         = ovf_q;
    first_d       = first_q;
    wr_en         = 1'b0;
    wr_addr       = '0;
    crc_en_d      = 1'b0;
    crc_clr_d     = 1'b0;
    crc_data_d    = crc_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    frame_len_d   = frame_len_q;

    unique case (state_q)
      StInit: begin
        if (!rx_valid && !rx_err && (sil_q == T35)) begin
          state_d = StIdle;
        end
      end

      // CHECK lasts one cycle and then behaves like IDLE, so a start byte there is kept.
      StIdle, StCheck: begin
        if (rx_err) begin
          state_d = StInit;
        end else if (rx_valid) begin
          state_d    = StRecv;
          cnt_d      = 9'd1;
          gap_d      = 1'b0;
          ovf_d      = 1'b0;
          first_d    = rx_data;
          wr_en      = 1'b1;
          wr_addr    = '0;
          crc_en_d   = 1'b1;
          crc_data_d = rx_data;
        end else begin
          state_d = StIdle;
        end
      end

      StRecv, StGap: begin
        if (rx_err) begin
          gap_d = 1'b1;
        end
        if (rx_valid) begin
          if (state_q == StGap) begin
            gap_d = 1'b1;
          end
          if (cnt_q < MaxLen) begin
            wr_en      = 1'b1;
            wr_addr    = AddrW'(cnt_q);
            crc_en_d   = 1'b1;
            crc_data_d = rx_data;
            cnt_d      = cnt_q + 9'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = StRecv;
        end else if (!rx_err) begin
          if ((state_q == StRecv) && (sil_q == T15)) begin
            state_d = StGap;
          end else if ((state_q == StGap) && (sil_q == T35)) begin
            // Verdict is registered here so the pulse lands in the CHECK cycle.
            state_d     = StCheck;
            frame_len_d = cnt_q;
            if (addr_ok) begin
              frame_err_d = 1'b1;
              if (gap_q) begin
                err_code_d = ErrGap;
              end else if (ovf_q) begin
                err_code_d = ErrOvf;
              end else if (cnt_q < 9'd4) begin
                err_code_d = ErrShort;
              end else if (crc_in != 16'h0000) begin
                err_code_d = ErrCrc;
              end else begin
                frame_err_d   = 1'b0;
                frame_valid_d = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = StInit;
      end
    endcase

    if (state_d == StCheck) begin
      crc_clr_d = 1'b1;
    end
    if ((state_d == StInit) && ((state_q != StInit) || init_q)) begin
      crc_clr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StInit;
      sil_q         <= '0;
      cnt_q         <= '0;
      gap_q         <= 1'b0;
      ovf_q         <= 1'b0;
      first_q       <= '0;
      init_q        <= 1'b1;
      crc_en_q      <= 1'b0;
      crc_clr_q     <= 1'b0;
      crc_data_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      frame_len_q   <= '0;
    end else begin
      state_q       <= state_d;
      sil_q         <= sil_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      ovf_q         <= ovf_d;
      first_q       <= first_d;
      init_q        <= 1'b0;
      crc_en_q      <= crc_en_d;
      crc_clr_q     <= crc_clr_d;
      crc_data_q    <= crc_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_len_q   <= frame_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      frame_mem[wr_addr] <= rx_data;
    end
  end

  assign rd_idx      = AddrW'(buf_rd_addr);
  assign rd_in_range = (32'(buf_rd_addr) < MAX_LEN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_in_range) begin
      rd_data_q <= frame_mem[rd_idx];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign crc_en      = crc_en_q;
  assign crc_clr     = crc_clr_q;
  assign crc_data    = crc_data_q;
  assign busy        = (state_q == StRecv) || (state_q == StGap) || (state_q == StCheck);
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_len   = frame_len_q;
  assign buf_rd_data = rd_data_q;

endmodule

// File: doc/modbus_rx_framer.md
# modbus_rx_framer

Receive-side framer for the Modbus RTU slave. It consumes bytes from the UART receiver and delimits frames by the t1.5 and t3.5 silence rules. Each accepted byte is streamed into the `crc_16` engine and also written into a frame buffer. At end of frame the block checks address, length and CRC residual, then raises either `frame_valid` or `frame_err` for the downstream request decoder.

## Interface
- `T15_CYCLES`, default 85938: clocks in 1.5 character times (50 MHz, 9600 baud).
- `T35_CYCLES`, default 200521: clocks in 3.5 character times; must exceed `T15_CYCLES`.
- `MAX_LEN`, default 256: frame buffer depth in bytes, including address and CRC.
- Ports:
  - `clk` in 1: single clock.
  - `rst_n` in 1: synchronous active-low reset.
  - `rx_data` in 8: byte from the UART.
  - `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
  - `rx_err` in 1: one-cycle UART framing/parity error strobe.
  - `dev_addr` in 8: this slave's address.
  - `crc_en` out 1: to `crc_16.crc_en`.
  - `crc_clr` out 1: to `crc_16.crc_clr`.
  - `crc_data` out 8: to `crc_16.data_in`.
  - `crc_in` in 16: from `crc_16.crc_out`.
  - `busy` out 1: frame reception in progress.
  - `frame_valid` out 1: one-cycle pulse, good frame addressed to us.
  - `frame_err` out 1: one-cycle pulse, bad frame addressed to us.
  - `err_code` out 2: 0 CRC, 1 short, 2 overflow, 3 gap/UART error; valid with `frame_err`.
  - `frame_len` out 9: total byte count including CRC; valid with either pulse.
  - `buf_rd_addr` in 8: buffer read address.
  - `buf_rd_data` out 8: buffer byte, registered, one-cycle read latency.

## Operation
- `crc_16` contract:
  - `crc_clr` loads 0xFFFF on the next edge and has priority over `crc_en`.
  - `crc_en` folds `crc_data` in on the next edge.
  - The Modbus CRC run over a whole frame, including its two CRC bytes sent low byte first, leaves a residual of 0x0000.
- Silence counter: cleared on every `rx_valid` or `rx_err`, otherwise increments and saturates at `T35_CYCLES`.
- States:
  - INIT (after reset): `crc_clr`=1 for one cycle. Discard all input until the counter reaches `T35_CYCLES`, then go to IDLE.
  - IDLE: on `rx_valid`, write the byte to buf[0], pulse `crc_en` with that byte, set count=1, go to RECV. `rx_err` in IDLE goes to INIT.
  - RECV:
    - Each `rx_valid` with count<MAX_LEN: write buf[count], pulse `crc_en`, count++.
    - Each `rx_valid` with count=MAX_LEN: set the overflow flag; count and buffer are unchanged.
    - `rx_err`: set the gap flag.
    - Counter reaching `T15_CYCLES`: go to GAP.
  - GAP:
    - `rx_valid` before t3.5: set the gap flag and return to RECV. The byte is processed as in RECV but the frame is doomed.
    - Counter reaching `T35_CYCLES`: go to CHECK.
  - CHECK (one cycle):
    - If buf[0]≠`dev_addr`, drop the frame silently with no pulse.
    - Otherwise pulse `frame_err` using priority gap(3) > overflow(2) > count<4 short(1) > `crc_in`≠0 CRC(0).
    - Otherwise pulse `frame_valid`.
    - In all cases drive `crc_clr`=1 and go to IDLE.
- `busy`=1 in RECV, GAP and CHECK.
- `frame_len`=count and is held until the next CHECK.
- Buffer contents are valid from the `frame_valid` pulse until the next `rx_valid` in IDLE. The consumer must finish reading before then.
- `crc_en` and `crc_clr` are never asserted in the same cycle.

## Timing
- Reset values: `crc_en`=0, `crc_clr`=0, `crc_data`=0, `busy`=0, `frame_valid`=0, `frame_err`=0, `err_code`=0, `frame_len`=0, `buf_rd_data`=0. State is INIT.
- `crc_en` and `crc_data` are registered: asserted the cycle after `rx_valid`. `crc_in` reflects that byte two cycles after `rx_valid`.
- Reaching t3.5 always comes at least 3 cycles after the last `crc_en`, so `crc_in` is settled when CHECK samples it.
- The pulse comes exactly one cycle after the counter equals `T35_CYCLES`.
- `rx_valid` arriving in the same cycle as the T15 or T35 threshold: the byte wins; the counter clears and the state does not advance.
- Reset asserted mid-frame: return to INIT, no pulses; the partial frame is lost.

## Configuration
- `MODBUS_RX_BROADCAST_EN`
  - Defined: address 0x00 is also accepted. Broadcast frames produce `frame_valid` or `frame_err` exactly as for own-address frames.
  - Undefined: 0x00 is treated as a mismatch and the frame is dropped silently.

## Test plan
Bench settings: `T15_CYCLES`=30, `T35_CYCLES`=70, `dev_addr`=0x01, bytes spaced 12 cycles apart.
- Good frame: after initial silence, send 01 03 00 00 00 01 84 0A. Expect `frame_valid` once, `frame_len`=8, buf[1]=0x03, `crc_in`=0x0000 at CHECK, then `crc_clr` pulse.
- CRC error: same frame with 84 0B. Expect `frame_err`, `err_code`=0, `frame_len`=8.
- Address mismatch: send 02 03 00 00 00 01 84 39 (valid CRC for address 02). Expect no pulse, and `busy` falls after t3.5.
- Gap: pause 40 cycles after byte 3, then send the rest. Expect `frame_err`, `err_code`=3. A following clean frame yields `frame_valid`.
- Short frame and `rx_err`: send 01 03 then silence; expect `err_code`=1, `frame_len`=2. Then `rx_err` mid-frame; expect `err_code`=3.
- Overflow and reset: send `MAX_LEN`+1 bytes; expect `err_code`=2, `frame_len`=`MAX_LEN`. Assert `rst_n`=0 mid-frame; expect no pulse, and the next frame is ignored until 70 quiet cycles have elapsed.
